posit_to_pif_pipe: RTL and testbench

Multi-lane, elastic-pipelined converter from posit words (parametrised N/ES) to the PIF form `{sign, te, mant}` used by the PPU datapath. It is the registered, back-pressurable successor of the single-lane combinational converter. It carries a per-lane special flag and a saturating NaR event counter for debug and exception reporting. It sits between the operand fetch interface and the PIF arithmetic core.

---
 rtl/ppu_pkg.sv | 36 +++
 rtl/pif_pipe_stage.sv | 28 ++
 rtl/posit_decode.sv | 63 ++++++
 rtl/posit_to_pif_pipe.sv | 94 +++++++++
 tb/tb_posit_to_pif_pipe.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared widths, PIF layout and helpers for the posit processing datapath.
package ppu_pkg;

  // Ceiling log2 for positive integers; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Signed total-exponent width: regime scaled by 2^ES plus the exponent field.
  function automatic int te_size(input int n, input int es);
    return es + clog2(n) + 1;
  endfunction

  // Hidden one plus the widest possible fraction.
  function automatic int mant_size(input int n);
    return n - 2;
  endfunction

  function automatic int pif_size(input int n, input int es);
    return 1 + te_size(n, es) + mant_size(n);
  endfunction

  // PIF layout for the default 8-bit, ES=0 configuration.
  localparam int PIF8_TE   = te_size(8, 0);
  localparam int PIF8_MANT = mant_size(8);

  typedef struct packed {
    logic                 sign;
    logic [PIF8_TE-1:0]   te;
    logic [PIF8_MANT-1:0] mant;
  } pif8_t;

endpackage

// File: rtl/pif_pipe_stage.sv
// One elastic register stage: loads whenever it is empty or its downstream accepts.
module pif_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [W-1:0] down_data
);

  assign up_ready = !down_valid || down_ready;

  // Valid follows the upstream on every load; data only moves on a real transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
    end else begin
      if (up_ready) down_valid <= up_valid;
      if (up_ready && up_valid) down_data <= up_data;
    end
  end

endmodule

// File: rtl/posit_decode.sv
// Combinational posit -> PIF {sign, te, mant} decode for one lane.
module posit_decode
  import ppu_pkg::*;
#(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input  logic [N-1:0]              posit,
  output logic [pif_size(N,ES)-1:0] pif,
  output logic                      special,
  output logic                      nar
);

  localparam int TE_SIZE   = te_size(N, ES);
  localparam int MANT_SIZE = mant_size(N);

  typedef struct packed {
    logic                 sign;
    logic [TE_SIZE-1:0]   te;
    logic [MANT_SIZE-1:0] mant;
  } pif_t;

  pif_t       d;
  logic [N-2:0] body;
  logic [N-2:0] rem;
  logic       regime;
  logic       done;
  int         run;
  int         e_val;
  int         te_val;

  // Regime run-length decode on the magnitude, then exponent and fraction from the remainder.
  always_comb begin
    body    = posit[N-1] ? (N-1)'(~posit + 1'b1) : posit[N-2:0];
    regime  = body[N-2];
    run     = 0;
    done    = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && (body[i] == regime)) run = run + 1;
      else done = 1'b1;
    end
    // Drop the regime run and its terminator; exponent bits now sit at the top.
    rem     = body << (run + 1);
    e_val   = int'(rem >> (N - 1 - ES));
    te_val  = (regime ? (run - 1) : -run) * (2 ** ES) + e_val;
    d.sign  = posit[N-1];
    d.te    = TE_SIZE'(te_val);
    d.mant  = MANT_SIZE'({1'b1, rem << ES} >> 2);
    special = 1'b0;
    nar     = 1'b0;
    if (posit == '0) begin
      d       = '0;
      special = 1'b1;
    end else if (posit == {1'b1, {(N-1){1'b0}}}) begin
      d       = '0;
      d.sign  = 1'b1;
      special = 1'b1;
      nar     = 1'b1;
    end
    pif = d;
  end

endmodule

// File: rtl/posit_to_pif_pipe.sv
// Multi-lane posit -> PIF converter behind an elastic pipeline, with a NaR event counter.
// Handshake: a beat transfers on a clock edge where valid && ready are both high; a
// producer holds valid and data stable until that edge, and ready may depend
// combinationally on the downstream ready.
module posit_to_pif_pipe
  import ppu_pkg::*;
#(
  parameter int N      = 8,
  parameter int ES     = 0,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*N-1:0]                in_posit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*pif_size(N,ES)-1:0]   out_pif,
  output logic [LANES-1:0]                  out_special,
  output logic [LANES-1:0]                  out_nar,
  input  logic                              clr_count,
  output logic [CNT_W-1:0]                  nar_count
);

  localparam int PIF_SIZE = pif_size(N, ES);
  localparam int DW       = LANES * (PIF_SIZE + 2);
  localparam int PW       = clog2(LANES + 1);
  localparam int SW       = ((CNT_W > PW) ? CNT_W : PW) + 1;

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("posit_to_pif_pipe: STAGES must be 1..3");
  end

  logic [LANES*PIF_SIZE-1:0] dec_pif;
  logic [LANES-1:0]          dec_special;
  logic [LANES-1:0]          dec_nar;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    posit_decode #(.N(N), .ES(ES)) u_dec (
      .posit   (in_posit[i*N +: N]),
      .pif     (dec_pif[i*PIF_SIZE +: PIF_SIZE]),
      .special (dec_special[i]),
      .nar     (dec_nar[i])
    );
  end

  logic [STAGES:0] valid_c;
  logic [STAGES:0] ready_c;
  logic [DW-1:0]   data_c [STAGES+1];

  assign valid_c[0]      = in_valid;
  assign data_c[0]       = {dec_pif, dec_special, dec_nar};
  assign ready_c[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    pif_pipe_stage #(.W(DW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (valid_c[s]),
      .up_ready   (ready_c[s]),
      .up_data    (data_c[s]),
      .down_valid (valid_c[s+1]),
      .down_ready (ready_c[s+1]),
      .down_data  (data_c[s+1])
    );
  end

  assign in_ready  = ready_c[0] && !rst;
  assign out_valid = valid_c[STAGES];
  assign {out_pif, out_special, out_nar} = data_c[STAGES];

  logic [PW-1:0]    pop;
  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] count_next;

  // Saturating add of the NaR lanes in the beat currently at the output.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(out_nar[i]);
    sum        = SW'(nar_count) + SW'(pop);
    count_next = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum);
  end

  // Counter advances on output handshakes; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nar_count <= '0;
    else if (clr_count) nar_count <= '0;
    else if (out_valid && out_ready) nar_count <= count_next;
  end

endmodule

// File: tb/tb_posit_to_pif_pipe.sv
// Directed and scoreboarded bench for posit_to_pif_pipe across STAGES=1/2/3 and CNT_W=2.
module tb_posit_to_pif_pipe;

  localparam logic [31:0] A_IN   = 32'h50C06040;
  localparam logic [43:0] A_PIF  = {11'h030, 11'h420, 11'h060, 11'h020};
  localparam logic [31:0] B_IN   = 32'h40808000;
  localparam logic [43:0] B_PIF  = {11'h020, 11'h400, 11'h400, 11'h000};
  localparam logic [31:0] NAR4   = 32'h80808080;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        clr_count;
  logic [31:0] in_posit;

  logic        ir2, ov2, ir1, ov1, ir3, ov3, irc, ovc;
  logic [43:0] pif2, pif1, pif3, pifc;
  logic [3:0]  spec2, spec1, spec3, specc, nar2, nar1, nar3, narc;
  logic [15:0] cnt2, cnt1, cnt3;
  logic [1:0]  cntc;

  int n_err = 0;
  int n_chk = 0;

  logic [51:0] exp_q[$];

  // Clock and global watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  posit_to_pif_pipe #(.N(8), .ES(0), .LANES(4), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_posit(in_posit),
    .out_valid(ov2), .out_ready(out_ready), .out_pif(pif2), .out_special(spec2),
    .out_nar(nar2), .clr_count(clr_count), .nar_count(cnt2)
  );

  posit_to_pif_pipe #(.N(8), .ES(0), .LANES(4), .STAGES(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_posit(in_posit),
    .out_valid(ov1), .out_ready(out_ready), .out_pif(pif1), .out_special(spec1),
    .out_nar(nar1), .clr_count(clr_count), .nar_count(cnt1)
  );

  posit_to_pif_pipe #(.N(8), .ES(0), .LANES(4), .STAGES(3), .CNT_W(16)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_posit(in_posit),
    .out_valid(ov3), .out_ready(out_ready), .out_pif(pif3), .out_special(spec3),
    .out_nar(nar3), .clr_count(clr_count), .nar_count(cnt3)
  );

  posit_to_pif_pipe #(.N(8), .ES(0), .LANES(4), .STAGES(2), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irc), .in_posit(in_posit),
    .out_valid(ovc), .out_ready(out_ready), .out_pif(pifc), .out_special(specc),
    .out_nar(narc), .clr_count(clr_count), .nar_count(cntc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode for N=8, ES=0 written from the posit definition.
  function automatic logic [10:0] ref_pif(input logic [7:0] p);
    logic [7:0] v;
    logic [5:0] mant;
    logic [3:0] te;
    logic       r;
    int         i, run, k;
    if (p == 8'h00) return 11'h000;
    if (p == 8'h80) return 11'h400;
    v   = p[7] ? (8'd0 - p) : p;
    r   = v[6];
    run = 0;
    i   = 6;
    while (i >= 0 && v[i] == r) begin
      run++;
      i--;
    end
    k    = r ? run - 1 : -run;
    te   = 4'(k);
    mant = 6'b100000;
    if (i >= 1) mant = mant | 6'((int'(v) & ((1 << i) - 1)) << (5 - i));
    return {p[7], te, mant};
  endfunction

  function automatic logic [51:0] exp_word(input logic [31:0] p);
    logic [43:0] pf;
    logic [3:0]  sp, nr;
    logic [7:0]  lane;
    for (int l = 0; l < 4; l++) begin
      lane            = p[l*8 +: 8];
      pf[l*11 +: 11]  = ref_pif(lane);
      sp[l]           = (lane == 8'h00) || (lane == 8'h80);
      nr[l]           = (lane == 8'h80);
    end
    return {nr, sp, pf};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] p);
    in_valid = 1'b1;
    in_posit = p;
    #1;
    check("send_in_ready", ir2, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // One beat through all pipeline depths: latency 1, 2 and 3 with identical data.
  task automatic run_beat_a();
    send_one(A_IN);
    check("a_s1_valid", ov1, 1);
    check("a_s1_pif", pif1, A_PIF);
    check("a_s2_early", ov2, 0);
    check("a_s3_early", ov3, 0);
    step();
    check("a_s2_valid", ov2, 1);
    check("a_s2_pif", pif2, A_PIF);
    check("a_s2_special", spec2, 4'b0000);
    check("a_s2_nar", nar2, 4'b0000);
    check("a_s1_drained", ov1, 0);
    check("a_s3_early2", ov3, 0);
    step();
    check("a_s3_valid", ov3, 1);
    check("a_s3_pif", pif3, A_PIF);
    check("a_s2_drained", ov2, 0);
    check("a_count", cnt2, 0);
    step();
  endtask

  task automatic drive_stream();
    logic [31:0] p;
    logic        acc;
    int          guard;
    for (int b = 0; b < 20; b++) begin
      for (int l = 0; l < 4; l++) p[l*8 +: 8] = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_posit = p;
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 100) begin
        #1;
        acc = ir2;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(exp_word(p));
        guard++;
      end
      if (!acc) check("stream_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor_stream();
    int          got, cyc, first, last, stall_left;
    logic [51:0] held, exp;
    got        = 0;
    cyc        = 0;
    first      = -1;
    last       = 0;
    stall_left = 0;
    held       = '0;
    while (got < 20 && cyc < 300) begin
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        if (stall_left == 5) held = {nar2, spec2, pif2};
        else check("stall_stable", {nar2, spec2, pif2}, held);
        if (stall_left <= 4) begin
          check("stall_in_ready", ir2, 0);
          check("stall_out_valid", ov2, 1);
        end
        stall_left--;
      end else if (ov2 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("stream_beat", {nar2, spec2, pif2}, exp);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        if (got == 8) stall_left = 5;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b1;
    check("stream_count", got, 20);
    check("stream_cycles", last - first, 24);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    in_posit  = '0;

    // Reset state
    step();
    step();
    check("rst_out_valid", ov2, 0);
    check("rst_out_pif", pif2, 0);
    check("rst_special", spec2, 0);
    check("rst_nar", nar2, 0);
    check("rst_count", cnt2, 0);
    check("rst_in_ready", ir2, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", ir2, 1);
    step();

    // Single beat, all depths
    run_beat_a();

    // Specials: zero and NaR lanes
    send_one(B_IN);
    step();
    check("b_valid", ov2, 1);
    check("b_pif", pif2, B_PIF);
    check("b_special", spec2, 4'b0111);
    check("b_nar", nar2, 4'b0110);
    step();
    check("b_count", cnt2, 2);
    check("b_count_c2", cntc, 2);
    check("b_drained", ov2, 0);
    step();

    // Saturation on the 2-bit counter
    send_one(NAR4);
    send_one(NAR4);
    send_one(NAR4);
    step();
    step();
    step();
    check("sat_count_c2", cntc, 3);
    check("sat_count_16", cnt2, 14);

    // Clear wins over a NaR beat delivered in the same cycle
    send_one(NAR4);
    step();
    check("clr_beat_valid", ov2, 1);
    check("clr_beat_nar", nar2, 4'b1111);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check("clr_count_16", cnt2, 0);
    check("clr_count_c2", cntc, 0);
    step();
    step();

    // Random stream with a mid-stream stall
    fork
      drive_stream();
      monitor_stream();
    join
    check("stream_q_empty", exp_q.size(), 0);
    step();
    step();
    step();

    // Reset with two beats in flight
    in_valid = 1'b1;
    in_posit = NAR4;
    step();
    step();
    check("flight_valid", ov2, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_valid", ov2, 0);
    check("async_rst_pif", pif2, 0);
    check("async_rst_count", cnt2, 0);
    check("async_rst_in_ready", ir2, 0);
    check("async_rst_s3_valid", ov3, 0);
    step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", ir2, 1);
    step();
    check("no_stale_1", ov2, 0);
    step();
    check("no_stale_2", ov2, 0);
    check("no_stale_count", cnt2, 0);

    // Latency after reset release
    run_beat_a();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
